// File: rtl/execute_muldiv.sv
// Iterative multiply / divide / modulo unit for the Execute stage.
// One result bit per cycle; div-by-zero and the reserved opcode finish early.
module execute_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] aluR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX
    } state_e;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_MOD = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    // acc: product accumulator (mul) or partial remainder (div/mod)
    // a:   shifted multiplicand (mul) or dividend shifting into quotient (div/mod)
    // b:   multiplier shifting right (mul) or divisor magnitude (div/mod)
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] alur_q, alur_d;

    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;

    // Unsigned negate keeps the magnitude of the most negative value at 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (WIDTH'(0) - v) : v;
    endfunction

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path through
        // the case statement can leave it unassigned and infer a latch.
        state_d = state_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        alur_d  = alur_q;
        done_d  = 1'b0;

        mul_sum = acc_q + (b_q[0] ? a_q : '0);
        rem_sh  = {acc_q, a_q[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, b_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    opa_d   = opA;
                    opb_d   = opB;
                    state_d = S_PREP;
                end
            end

            S_PREP: begin
                if (op_q == OP_RSV) begin
                    alur_d  = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (op_q != OP_MUL && opb_q == '0) begin
                    alur_d  = (op_q == OP_DIV) ? '1 : opa_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                    if (op_q == OP_MUL) begin
                        a_d   = opa_q;
                        b_d   = opb_q;
                        neg_d = 1'b0;
                    end else begin
                        a_d   = mag(opa_q);
                        b_d   = mag(opb_q);
                        // Truncating division: quotient sign is the XOR, remainder follows the dividend.
                        neg_d = (op_q == OP_DIV) ? (opa_q[WIDTH-1] ^ opb_q[WIDTH-1])
                                                 : opa_q[WIDTH-1];
                    end
                end
            end

            S_CALC: begin
                if (op_q == OP_MUL) begin
                    acc_d = mul_sum;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else if (!rem_sub[WIDTH]) begin
                    acc_d = rem_sub[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                case (op_q)
                    OP_MUL:  alur_d = acc_q;
                    OP_DIV:  alur_d = neg_q ? (WIDTH'(0) - a_q) : a_q;
                    OP_MOD:  alur_d = neg_q ? (WIDTH'(0) - acc_q) : acc_q;
                    default: alur_d = '0;
                endcase
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            alur_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            alur_q  <= alur_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign aluR = alur_q;

endmodule
